mips32_mem_arbiter: RTL and testbench
=====================================

# mips32_mem_arbiter

- Shares one single-port, word-addressed instruction/data memory between two requesters of the MIPS32 pipeline: the instruction-fetch (IF) port and the data (MEM-stage LW/SW) port.
- Grants at most one access per cycle and returns read data one cycle after the grant.
- Drops a fetch response that is flushed by a taken branch.
- Prevents starvation of either port with a bounded-streak fairness rule.

## Interface

Parameters:
- ADDR_W, default 10: word-address width (1024-word memory).
- DATA_W, default 32: data word width.
- STARVE_LIMIT, default 4: maximum consecutive contended data grants before IF is forced to win; legal range 1..15.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: synchronous, active-low reset.
- if_req, in, 1: fetch request; held with if_addr stable until if_gnt.
- if_addr, in, ADDR_W: fetch word address.
- if_flush, in, 1: taken-branch flush; discards the outstanding fetch response.
- if_gnt, out, 1: fetch accepted this cycle (combinational).
- if_rvalid, out, 1: fetch data valid.
- if_rdata, out, DATA_W: fetch data.
- d_req, in, 1: data request; held with d_we/d_addr/d_wdata stable until d_gnt.
- d_we, in, 1: 1 = store, 0 = load.
- d_addr, in, ADDR_W: data word address.
- d_wdata, in, DATA_W: store data.
- d_gnt, out, 1: data access accepted this cycle (combinational).
- d_rvalid, out, 1: load data valid; never asserted for stores.
- d_rdata, out, DATA_W: load data.
- halt, in, 1: pipeline halted; blocks new IF grants; data grants unaffected.
- mem_en, out, 1: memory access strobe; equals if_gnt | d_gnt.
- mem_we, out, 1: memory write enable; equals d_gnt & d_we.
- mem_addr, out, ADDR_W: address of the granted port; 0 when idle.
- mem_wdata, out, DATA_W: d_wdata when a store is granted; otherwise 0.
- mem_rdata, in, DATA_W: memory read data, valid one cycle after a read mem_en.

## Operation

- Eligibility: IF is eligible when if_req & ~halt & ~if_flush. Data is eligible when d_req.
- Only one port eligible: that port is granted.
- Both eligible (contention): data wins unless streak == STARVE_LIMIT, in which case IF wins.
- streak is a 4-bit counter:
  - Increments on each contended data grant.
  - Clears on any IF grant, or on any cycle where IF is not eligible.
  - Saturates at STARVE_LIMIT.
- Response tracking uses registers pend_if and pend_d.
  - pend_if is set on a cycle with if_gnt.
  - pend_d is set on a cycle with d_gnt & ~d_we.
  - Both clear otherwise.
- if_rvalid = pend_if & ~flushed.
  - flushed is set when if_flush is high in the grant cycle or in the response cycle, so no response is produced for a flushed fetch.
  - if_rdata = mem_rdata, and is 0 when if_rvalid is low.
- d_rvalid = pend_d; d_rdata = mem_rdata, and is 0 when d_rvalid is low.
- halt high: fetch issue stops. An already-pending fetch response is still delivered.
- A store and a subsequent load to the same address in back-to-back cycles return the stored value; the memory provides write-before-read ordering across cycles.

## Timing

- Grant latency: 0 cycles; grant is combinational from the registered streak plus the inputs.
- Read latency: rvalid is asserted exactly 1 cycle after the grant.
- Throughput: one access per cycle. The losing port waits at most STARVE_LIMIT cycles under continuous contention.
- Reset (rst_n low at an edge) clears streak, pend_if, pend_d and flushed.
  - All registered outputs return to 0 on the next cycle.
  - Any response in flight is discarded.
  - Combinational grants are forced to 0 while rst_n is low.
- Simultaneous if_flush and if_req in one cycle: no IF grant and no response; data may be granted.

## Structure

- Shared package mips32_pkg holds:
  - Port-select encoding: PORT_NONE, PORT_IF, PORT_D.
  - ADDR_W/DATA_W defaults shared with the pipeline.
- Single module; no sub-module. The streak counter and the response tracker are local always blocks.

## Test plan

- IF-only reads: if_req=1 with if_addr=0,1,2 and mem holding 0xA0,0xA1,0xA2 -> if_gnt every cycle; if_rvalid one cycle later with those data in order.
- Contention, STARVE_LIMIT=4: if_req and d_req (load, addr 100) held high continuously -> grant pattern D,D,D,D,IF repeating; d_rvalid count = 4 per 5 cycles.
- Store then load: SW addr 5 data 0xDEADBEEF, then LW addr 5 -> mem_we pulses once; d_rvalid with 0xDEADBEEF; no d_rvalid for the store.
- Flush: IF granted addr 8, if_flush=1 in the next cycle -> if_rvalid stays 0; a subsequent grant to addr 20 returns valid data.
- Halt: halt=1 with if_req=1 and d_req=1 -> only d_gnt; an IF response already pending still emerges once.
- Reset mid-read: rst_n=0 in the cycle after a load grant -> d_rvalid=0 and all outputs 0; after release, the streak starts from 0.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: memory geometry and arbiter port-select encoding.
package mips32_pkg;

   localparam int MIPS_ADDR_W = 10;
   localparam int MIPS_DATA_W = 32;

   typedef enum logic [1:0] {
      PORT_NONE = 2'd0,
      PORT_IF   = 2'd1,
      PORT_D    = 2'd2
   } port_sel_e;

endpackage

// File: rtl/mips32_mem_arbiter_if.sv
// Bus bundle between the pipeline (fetch + data requesters), the arbiter and memory.
// master: pipeline/memory side, slave: arbiter side.
interface mips32_mem_arbiter_if
   import mips32_pkg::*;
#(
   parameter int ADDR_W = MIPS_ADDR_W,
   parameter int DATA_W = MIPS_DATA_W
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_flush;
   logic              if_gnt;
   logic              if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              halt;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, halt, mem_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
             mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mips32_mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and MEM-stage loads/stores.
// Data wins contention until it has won STARVE_LIMIT contended cycles in a row,
// then fetch is forced through. Read data returns one cycle after the grant.
module mips32_mem_arbiter
   import mips32_pkg::*;
#(
   parameter int ADDR_W       = MIPS_ADDR_W,
   parameter int DATA_W       = MIPS_DATA_W,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   mips32_mem_arbiter_if.slave  bus
);

   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] streak_q, streak_d;
   logic       pend_if_q, pend_if_d;
   logic       pend_d_q, pend_d_d;
   logic       flushed_q, flushed_d;
   logic       if_elig, d_elig, contend;
   port_sel_e  sel;

   // Grant selection; nothing is granted while reset is held.
   always_comb begin
      if_elig = bus.if_req & ~bus.halt & ~bus.if_flush;
      d_elig  = bus.d_req;
      contend = if_elig & d_elig;
      sel     = PORT_NONE;
      if (!rst_n)        sel = PORT_NONE;
      else if (contend)  sel = (streak_q == LIMIT) ? PORT_IF : PORT_D;
      else if (if_elig)  sel = PORT_IF;
      else if (d_elig)   sel = PORT_D;
   end

   assign bus.if_gnt    = (sel == PORT_IF);
   assign bus.d_gnt     = (sel == PORT_D);
   assign bus.mem_en    = bus.if_gnt | bus.d_gnt;
   assign bus.mem_we    = bus.d_gnt & bus.d_we;
   assign bus.mem_addr  = bus.if_gnt ? bus.if_addr :
                          bus.d_gnt  ? bus.d_addr  : '0;
   assign bus.mem_wdata = bus.mem_we ? bus.d_wdata : '0;

   // A fetch response is dropped if a flush arrives in its grant or response cycle;
   // responses in flight while reset is asserted are discarded.
   assign bus.if_rvalid = pend_if_q & ~(flushed_q | bus.if_flush) & rst_n;
   assign bus.d_rvalid  = pend_d_q & rst_n;
   assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
   assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : '0;

   // Next-state for the fairness streak and the response tracker.
   always_comb begin
      streak_d = streak_q;
      if (!if_elig || bus.if_gnt)
         streak_d = '0;
      else if (contend && bus.d_gnt && streak_q != LIMIT)
         streak_d = streak_q + 4'd1;
      pend_if_d = bus.if_gnt;
      pend_d_d  = bus.d_gnt & ~bus.d_we;
      flushed_d = bus.if_gnt & bus.if_flush;
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         streak_q  <= '0;
         pend_if_q <= 1'b0;
         pend_d_q  <= 1'b0;
         flushed_q <= 1'b0;
      end else begin
         streak_q  <= streak_d;
         pend_if_q <= pend_if_d;
         pend_d_q  <= pend_d_d;
         flushed_q <= flushed_d;
      end
   end

endmodule

// File: tb/tb_mips32_mem_arbiter.sv
// Scoreboard bench for mips32_mem_arbiter: a per-cycle reference model predicts
// grants and queues expected read data; a monitor pops on every rvalid.
module tb_mips32_mem_arbiter;
   localparam int AW = 10;
   localparam int DW = 32;
   localparam int LIM = 4;

   logic clk = 0;
   logic rst_n;
   always #5 clk = ~clk;

   mips32_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

   mips32_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave)
   );

   int total = 0, bad = 0;
   int drv_cnt = 0, we_cnt = 0;
   logic [DW-1:0] mem [1<<AW];
   logic [DW-1:0] ref_mem [1<<AW];
   logic [DW-1:0] exp_if_q[$], exp_d_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Environment memory: write-before-read across cycles, one-cycle read latency.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
         else            bus.mem_rdata     <= mem[bus.mem_addr];
      end
   end

   // Reference model: decide grants from the eligibility and fairness rules.
   int            run = 0;
   logic          m_pif = 0, m_pd = 0;
   logic [DW-1:0] m_pif_dat, m_pd_dat;
   always @(negedge clk) begin
      logic ie, de, ei, ed;
      logic [AW-1:0] ea;
      logic [DW-1:0] ew;
      if (m_pif && rst_n && !bus.if_flush) exp_if_q.push_back(m_pif_dat);
      if (m_pd && rst_n) exp_d_q.push_back(m_pd_dat);
      ie = bus.if_req && !bus.halt && !bus.if_flush;
      de = bus.d_req;
      ei = 0; ed = 0;
      if (rst_n) begin
         if (ie && de) begin
            if (run == LIM) ei = 1; else ed = 1;
         end else if (ie) ei = 1;
         else if (de) ed = 1;
      end
      ea = ei ? bus.if_addr : ed ? bus.d_addr : '0;
      ew = (ed && bus.d_we) ? bus.d_wdata : '0;
      chk("if_gnt", 32'(bus.if_gnt), 32'(ei));
      chk("d_gnt", 32'(bus.d_gnt), 32'(ed));
      chk("mem_en", 32'(bus.mem_en), 32'(ei | ed));
      chk("mem_we", 32'(bus.mem_we), 32'(ed & bus.d_we));
      chk("mem_addr", 32'(bus.mem_addr), 32'(ea));
      chk("mem_wdata", bus.mem_wdata, ew);
      if (!rst_n || !ie || ei) run = 0;
      else if (ed && run < LIM) run++;
      m_pif = ei;
      m_pif_dat = ref_mem[bus.if_addr];
      m_pd = ed && !bus.d_we;
      m_pd_dat = ref_mem[bus.d_addr];
      if (ed && bus.d_we) ref_mem[bus.d_addr] = bus.d_wdata;
   end

   // Monitor: pop on each rvalid; data must be 0 when not valid; no response may go missing.
   always @(negedge clk) begin
      #1;
      if (bus.mem_we) we_cnt++;
      if (bus.if_rvalid) begin
         if (exp_if_q.size() == 0) chk("if_rvalid_unexpected", 1, 0);
         else chk("if_rdata", bus.if_rdata, exp_if_q.pop_front());
      end else chk("if_rdata_idle", bus.if_rdata, 0);
      if (bus.d_rvalid) begin
         drv_cnt++;
         if (exp_d_q.size() == 0) chk("d_rvalid_unexpected", 1, 0);
         else chk("d_rdata", bus.d_rdata, exp_d_q.pop_front());
      end else chk("d_rdata_idle", bus.d_rdata, 0);
      if (exp_if_q.size() != 0) begin chk("if_rvalid_missing", 0, 1); exp_if_q.delete(); end
      if (exp_d_q.size() != 0) begin chk("d_rvalid_missing", 0, 1); exp_d_q.delete(); end
   end

   logic ig = 0, dg = 0;
   task automatic step();
      @(negedge clk);
      ig = bus.if_gnt;
      dg = bus.d_gnt;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.if_req = 0; bus.if_flush = 0; bus.d_req = 0; bus.d_we = 0; bus.halt = 0;
   endtask

   initial begin
      int c0;
      for (int i = 0; i < (1 << AW); i++) begin
         logic [DW-1:0] v;
         v = $urandom;
         mem[i] = v; ref_mem[i] = v;
      end
      for (int i = 0; i < 3; i++) begin
         mem[i] = 32'hA0 + 32'(i); ref_mem[i] = 32'hA0 + 32'(i);
      end
      bus.mem_rdata = '0;
      bus.if_addr = '0; bus.d_addr = '0; bus.d_wdata = '0;
      idle();
      // Reset: grants forced low even with requests pending.
      rst_n = 0;
      bus.if_req = 1; bus.d_req = 1;
      step(); step();
      chk("rst_if_rvalid", 32'(bus.if_rvalid), 0);
      chk("rst_d_rvalid", 32'(bus.d_rvalid), 0);
      chk("rst_if_gnt", 32'(bus.if_gnt), 0);
      idle();
      rst_n = 1;
      step();
      // IF-only reads of 0,1,2.
      for (int i = 0; i < 3; i++) begin
         bus.if_req = 1; bus.if_addr = AW'(i);
         step();
      end
      idle(); step();
      // Continuous contention: D,D,D,D,IF.
      bus.if_req = 1; bus.if_addr = 10'd50;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'd100;
      step(); step();
      c0 = drv_cnt;
      for (int i = 0; i < 10; i++) step();
      chk("contention_d_rvalid_per10", drv_cnt - c0, 8);
      idle(); step();
      // Store then load to the same address.
      c0 = we_cnt;
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 10'd5; bus.d_wdata = 32'hDEADBEEF;
      step();
      bus.d_we = 0; bus.d_wdata = '0;
      step();
      idle(); step(); step();
      chk("store_we_pulses", we_cnt - c0, 1);
      // Flush of a granted fetch, then a clean fetch.
      bus.if_req = 1; bus.if_addr = 10'd8;
      step();
      bus.if_req = 0; bus.if_flush = 1;
      step();
      bus.if_flush = 0; bus.if_req = 1; bus.if_addr = 10'd20;
      step();
      idle(); step();
      // Halt with a fetch response already pending.
      bus.if_req = 1; bus.if_addr = 10'd3;
      step();
      bus.halt = 1; bus.if_addr = 10'd4;
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'd7;
      step(); step();
      idle(); step();
      // Reset in the cycle after a load grant.
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 10'd9;
      step();
      bus.d_req = 0; rst_n = 0;
      step();
      chk("rst_mid_d_rvalid", 32'(bus.d_rvalid), 0);
      chk("rst_mid_mem_en", 32'(bus.mem_en), 0);
      rst_n = 1;
      bus.if_req = 1; bus.if_addr = 10'd60;
      bus.d_req = 1; bus.d_addr = 10'd61;
      for (int i = 0; i < 6; i++) step();
      idle(); step();
      // Randomized traffic honouring the hold-until-grant protocol.
      for (int n = 0; n < 3000; n++) begin
         if (!bus.if_req || ig) begin
            bus.if_req = ($urandom_range(0, 3) != 0);
            bus.if_addr = AW'($urandom_range(0, 31));
         end
         if (!bus.d_req || dg) begin
            bus.d_req = ($urandom_range(0, 2) != 0);
            bus.d_we = $urandom_range(0, 1) == 1;
            bus.d_addr = AW'($urandom_range(0, 31));
            bus.d_wdata = $urandom;
         end
         bus.if_flush = ($urandom_range(0, 9) == 0);
         bus.halt = ($urandom_range(0, 9) == 0);
         rst_n = !((n % 700) == 350);
         step();
      end
      idle(); rst_n = 1;
      step(); step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
